ysyx_23060124_wbu: RTL and testbench
====================================

# ysyx_23060124_wbu

Write-back/commit stage of the ysyx_23060124 RV32E core. It sits directly downstream of the EXU→WBU pipeline register and consumes its outputs: result, rd, CSR address, write enables, and control flags. It owns the 16×32 GPR file and the machine-mode CSR file (including the mcycle/minstret counters), retires one instruction per accepted handshake, and issues a registered PC redirect to the IFU.

## Interface
- No parameters.
- clock  in  1  core clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- i_valid  in  1  upstream holds a valid instruction (driven by the pipeline register's o_next)
- o_ready  out  1  WBU can commit; = ~o_halt
- i_pc, i_pc_next  in  32  PC of the instruction; EXU-computed next PC
- i_res  in  32  ALU/LSU result or CSR write data
- i_rd_addr  in  4  GPR destination
- i_csr_addr  in  12  CSR destination
- i_wen, i_csr_wen, i_ecall, i_mret, i_ebreak  in  1  commit controls
- i_raddr1, i_raddr2  in  4  GPR read addresses (IDU)
- o_rdata1, o_rdata2  out  32  GPR read data, combinational
- i_csr_raddr  in  12  CSR read address (EXU)
- o_csr_rdata  out  32  CSR read data, combinational
- o_redirect_valid  out  1  one-cycle pulse: fetch from o_redirect_pc
- o_redirect_pc  out  32  next fetch PC
- o_retire  out  1  one-cycle pulse per committed instruction
- o_halt  out  1  sticky; set by ebreak commit

## Operation
- Commit = i_valid & o_ready at a rising edge. No commit means no architectural update except mcycle.
- GPR: x0 reads 0, and writes to x0 are dropped. On commit with i_wen, rf[i_rd_addr] ← i_res.
- GPR read bypass: when a commit writes rd≠0 and raddr==rd in the same cycle, o_rdata returns i_res. Otherwise it returns the stored value.
- CSRs implemented:
  - mstatus 0x300
  - mtvec 0x305
  - mepc 0x341
  - mcause 0x342
  - mcycle 0xB00 / mcycleh 0xB80
  - minstret 0xB02 / minstreth 0xB82
  - mvendorid 0xF11 = 0x79737978 (read-only)
  - marchid 0xF12 = 0x015FDF0C (read-only)
- Unimplemented CSR addresses read 0; writes to them are ignored. Writes to read-only CSRs are ignored.
- CSR read bypass: same rule as GPR, for a committing i_csr_wen with matching address. No bypass for ecall/mret side effects.
- Commit priority: ecall > mret > normal. Only one of these actions is applied; i_wen GPR write is applied in all cases.
- ecall:
  - mepc ← i_pc; mcause ← 11.
  - mstatus.MPIE(7) ← MIE(3); MIE ← 0; MPP(12:11) ← 2'b11.
  - Redirect to {mtvec[31:2], 2'b00}.
  - i_csr_wen is ignored.
- mret:
  - mstatus.MIE ← MPIE; MPIE ← 1; MPP ← 2'b11.
  - Redirect to mepc, using the value before any same-cycle update.
- normal: if i_csr_wen, CSR[i_csr_addr] ← i_res. Redirect to i_pc_next.
- ebreak: commits normally (GPR write, retire, redirect to i_pc_next). It then sets o_halt, so o_ready=0 forever until reset.
- Counters (64-bit, wrap modulo 2^64):
  - mcycle +1 every cycle while reset is deasserted.
  - minstret +1 per commit.
  - An explicit CSR write to a counter half replaces that half's value for the cycle; no increment is applied to the written half. The other half still carries if applicable.

## Timing
- Reset values:
  - All GPRs 0.
  - mstatus 0x00001800; mtvec, mepc, mcause 0.
  - mcycle, minstret 0.
  - o_redirect_valid 0, o_redirect_pc 0, o_retire 0, o_halt 0.
  - o_ready 1.
- Reset is asynchronous. Asserting it mid-commit discards the commit and clears pending pulses.
- Latency:
  - Architectural state is visible on read ports combinationally in the cycle after the commit edge.
  - o_redirect_valid, o_redirect_pc, and o_retire are registered and high exactly one cycle after the commit edge.
- Throughput: one commit per cycle. Back-to-back commits give continuous redirect/retire pulses.
- o_halt rises in the cycle after the ebreak commit edge, and o_ready falls in that same cycle. An i_valid present then is not committed.
- o_ready is independent of i_valid, so there is no combinational loop.

## Test plan
- Reset with reset=0, then release: all reads return 0; mstatus reads 0x1800; o_ready=1. After 5 cycles, mcycle reads 5 and minstret reads 0.
- Commit rd=5, i_res=0xDEADBEEF, i_pc_next=0x80000004, with i_raddr1=5 in the same cycle:
  - o_rdata1=0xDEADBEEF via bypass.
  - Next cycle: o_redirect_valid=1, o_redirect_pc=0x80000004, o_retire=1.
  - A commit with rd=0 leaves x0 reading 0.
- Write mtvec=0x80000101 via i_csr_wen, then ecall at i_pc=0x80000010:
  - Redirect to 0x80000100.
  - mepc=0x80000010, mcause=11.
  - mstatus = 0x1800 with MIE=0, and MPIE = the prior MIE.
- Set mstatus=0x00000080, then mret: redirect to the current mepc and mstatus reads 0x00001888. Also present ecall+mret together: ecall behaviour only.
- Write mcycle=0xFFFFFFFF, then idle 2 cycles: mcycleh increments by 1 and mcycle low reads 1.
- ebreak commit with i_wen rd=1: x1 is written and o_retire pulses. The next cycle has o_halt=1 and o_ready=0; further i_valid causes no state change. Async reset restores o_ready=1.

Source files
------------

// File: rtl/ysyx_23060124_wbu.sv
// Write-back/commit stage: owns the GPR file and machine-mode CSRs, retires one
// instruction per accepted handshake and issues a registered PC redirect.
module ysyx_23060124_wbu (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_next,
    input  logic [31:0] i_res,
    input  logic [3:0]  i_rd_addr,
    input  logic [11:0] i_csr_addr,
    input  logic        i_wen,
    input  logic        i_csr_wen,
    input  logic        i_ecall,
    input  logic        i_mret,
    input  logic        i_ebreak,
    input  logic [3:0]  i_raddr1,
    input  logic [3:0]  i_raddr2,
    output logic [31:0] o_rdata1,
    output logic [31:0] o_rdata2,
    input  logic [11:0] i_csr_raddr,
    output logic [31:0] o_csr_rdata,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    output logic        o_retire,
    output logic        o_halt
);
    // Handshake: a commit happens on a rising edge where i_valid & o_ready.
    // o_ready depends only on the halt state, never on i_valid.

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;

    localparam logic [31:0] MVENDORID_VAL = 32'h7973_7978;
    localparam logic [31:0] MARCHID_VAL   = 32'h015F_DF0C;
    localparam logic [31:0] MSTATUS_RST   = 32'h0000_1800;
    localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e      state_q;
    logic [31:0] rf_q [0:15];
    logic [31:0] mstatus_q, mtvec_q, mepc_q, mcause_q;
    logic [31:0] mcycle_lo_q, mcycle_hi_q, minstret_lo_q, minstret_hi_q;
    logic        redirect_valid_q, retire_q;
    logic [31:0] redirect_pc_q;

    logic [31:0] mstatus_d, mtvec_d, mepc_d, mcause_d;
    logic [31:0] mcycle_lo_d, mcycle_hi_d, minstret_lo_d, minstret_hi_d;
    logic [32:0] mcycle_lo_inc, minstret_lo_inc;
    logic [31:0] redirect_target;

    logic commit, gpr_wr, do_ecall, do_mret, do_csr_wr;
    logic wr_mstatus, wr_mtvec, wr_mepc, wr_mcause;
    logic wr_mcycle, wr_mcycleh, wr_minstret, wr_minstreth, csr_wr_hit;

    assign o_ready          = (state_q == ST_RUN);
    assign o_halt           = (state_q == ST_HALT);
    assign o_redirect_valid = redirect_valid_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_retire         = retire_q;

    // ecall wins over mret, which wins over a plain CSR write.
    assign commit    = i_valid & o_ready;
    assign gpr_wr    = commit & i_wen & (i_rd_addr != 4'd0);
    assign do_ecall  = commit & i_ecall;
    assign do_mret   = commit & i_mret & ~i_ecall;
    assign do_csr_wr = commit & i_csr_wen & ~i_ecall & ~i_mret;

    assign wr_mstatus   = do_csr_wr & (i_csr_addr == CSR_MSTATUS);
    assign wr_mtvec     = do_csr_wr & (i_csr_addr == CSR_MTVEC);
    assign wr_mepc      = do_csr_wr & (i_csr_addr == CSR_MEPC);
    assign wr_mcause    = do_csr_wr & (i_csr_addr == CSR_MCAUSE);
    assign wr_mcycle    = do_csr_wr & (i_csr_addr == CSR_MCYCLE);
    assign wr_mcycleh   = do_csr_wr & (i_csr_addr == CSR_MCYCLEH);
    assign wr_minstret  = do_csr_wr & (i_csr_addr == CSR_MINSTRET);
    assign wr_minstreth = do_csr_wr & (i_csr_addr == CSR_MINSTRETH);
    assign csr_wr_hit   = wr_mstatus | wr_mtvec | wr_mepc | wr_mcause |
                          wr_mcycle | wr_mcycleh | wr_minstret | wr_minstreth;

    // A written counter half takes i_res; the other half still sees the carry.
    assign mcycle_lo_inc   = {1'b0, mcycle_lo_q} + 33'd1;
    assign minstret_lo_inc = {1'b0, minstret_lo_q} + {32'd0, commit};
    assign mcycle_lo_d     = wr_mcycle    ? i_res : mcycle_lo_inc[31:0];
    assign mcycle_hi_d     = wr_mcycleh   ? i_res : mcycle_hi_q + {31'd0, mcycle_lo_inc[32]};
    assign minstret_lo_d   = wr_minstret  ? i_res : minstret_lo_inc[31:0];
    assign minstret_hi_d   = wr_minstreth ? i_res : minstret_hi_q + {31'd0, minstret_lo_inc[32]};

    assign mtvec_d  = wr_mtvec ? i_res : mtvec_q;
    assign mepc_d   = do_ecall ? i_pc : (wr_mepc ? i_res : mepc_q);
    assign mcause_d = do_ecall ? CAUSE_ECALL_M : (wr_mcause ? i_res : mcause_q);

    always_comb begin
        mstatus_d = mstatus_q;
        if (do_ecall) begin
            mstatus_d[7]     = mstatus_q[3];
            mstatus_d[3]     = 1'b0;
            mstatus_d[12:11] = 2'b11;
        end else if (do_mret) begin
            mstatus_d[3]     = mstatus_q[7];
            mstatus_d[7]     = 1'b1;
            mstatus_d[12:11] = 2'b11;
        end else if (wr_mstatus) begin
            mstatus_d = i_res;
        end
    end

    // mret returns to the mepc held before this edge.
    always_comb begin
        redirect_target = i_pc_next;
        if (do_ecall) begin
            redirect_target = {mtvec_q[31:2], 2'b00};
        end else if (do_mret) begin
            redirect_target = mepc_q;
        end
    end

    always_comb begin
        o_rdata1 = 32'd0;
        o_rdata2 = 32'd0;
        if (i_raddr1 != 4'd0) begin
            o_rdata1 = (gpr_wr && (i_raddr1 == i_rd_addr)) ? i_res : rf_q[i_raddr1];
        end
        if (i_raddr2 != 4'd0) begin
            o_rdata2 = (gpr_wr && (i_raddr2 == i_rd_addr)) ? i_res : rf_q[i_raddr2];
        end
    end

    // Bypass only forwards writes that will actually land in a CSR.
    always_comb begin
        case (i_csr_raddr)
            CSR_MSTATUS:   o_csr_rdata = mstatus_q;
            CSR_MTVEC:     o_csr_rdata = mtvec_q;
            CSR_MEPC:      o_csr_rdata = mepc_q;
            CSR_MCAUSE:    o_csr_rdata = mcause_q;
            CSR_MCYCLE:    o_csr_rdata = mcycle_lo_q;
            CSR_MCYCLEH:   o_csr_rdata = mcycle_hi_q;
            CSR_MINSTRET:  o_csr_rdata = minstret_lo_q;
            CSR_MINSTRETH: o_csr_rdata = minstret_hi_q;
            CSR_MVENDORID: o_csr_rdata = MVENDORID_VAL;
            CSR_MARCHID:   o_csr_rdata = MARCHID_VAL;
            default:       o_csr_rdata = 32'd0;
        endcase
        if (csr_wr_hit && (i_csr_raddr == i_csr_addr)) begin
            o_csr_rdata = i_res;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_RUN;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 32'd0;
            end
            mstatus_q        <= MSTATUS_RST;
            mtvec_q          <= 32'd0;
            mepc_q           <= 32'd0;
            mcause_q         <= 32'd0;
            mcycle_lo_q      <= 32'd0;
            mcycle_hi_q      <= 32'd0;
            minstret_lo_q    <= 32'd0;
            minstret_hi_q    <= 32'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
            retire_q         <= 1'b0;
        end else begin
            if (gpr_wr) begin
                rf_q[i_rd_addr] <= i_res;
            end
            mstatus_q        <= mstatus_d;
            mtvec_q          <= mtvec_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mcycle_lo_q      <= mcycle_lo_d;
            mcycle_hi_q      <= mcycle_hi_d;
            minstret_lo_q    <= minstret_lo_d;
            minstret_hi_q    <= minstret_hi_d;
            redirect_valid_q <= commit;
            retire_q         <= commit;
            if (commit) begin
                redirect_pc_q <= redirect_target;
            end
            case (state_q)
                ST_RUN:  if (commit && i_ebreak) state_q <= ST_HALT;
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060124_wbu.sv
// Bench for ysyx_23060124_wbu: directed scenarios plus randomized commits
// checked against an architectural model of GPRs, CSRs and counters.
module tb_ysyx_23060124_wbu;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_valid, o_ready;
    logic [31:0] i_pc, i_pc_next, i_res;
    logic [3:0]  i_rd_addr, i_raddr1, i_raddr2;
    logic [11:0] i_csr_addr, i_csr_raddr;
    logic        i_wen, i_csr_wen, i_ecall, i_mret, i_ebreak;
    logic [31:0] o_rdata1, o_rdata2, o_csr_rdata, o_redirect_pc;
    logic        o_redirect_valid, o_retire, o_halt;

    int n_checks = 0;
    int n_fail   = 0;

    ysyx_23060124_wbu dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_pc_next(i_pc_next), .i_res(i_res), .i_rd_addr(i_rd_addr),
        .i_csr_addr(i_csr_addr), .i_wen(i_wen), .i_csr_wen(i_csr_wen),
        .i_ecall(i_ecall), .i_mret(i_mret), .i_ebreak(i_ebreak),
        .i_raddr1(i_raddr1), .i_raddr2(i_raddr2), .o_rdata1(o_rdata1), .o_rdata2(o_rdata2),
        .i_csr_raddr(i_csr_raddr), .o_csr_rdata(o_csr_rdata),
        .o_redirect_valid(o_redirect_valid), .o_redirect_pc(o_redirect_pc),
        .o_retire(o_retire), .o_halt(o_halt)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [31:0] m_gpr [0:15];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    logic [63:0] m_mcycle, m_minstret;
    logic        m_halt;
    logic        m_commit_q;
    logic [31:0] m_target_q;

    logic [11:0] csr_list [0:10] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00,
                                     12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h123};

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_gpr[i] = 32'd0;
        m_mstatus  = 32'h0000_1800;
        m_mtvec    = 32'd0;
        m_mepc     = 32'd0;
        m_mcause   = 32'd0;
        m_mcycle   = 64'd0;
        m_minstret = 64'd0;
        m_halt     = 1'b0;
        m_commit_q = 1'b0;
        m_target_q = 32'd0;
    endtask

    function automatic logic [31:0] model_csr(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_mcycle[31:0];
            12'hB80: return m_mcycle[63:32];
            12'hB02: return m_minstret[31:0];
            12'hB82: return m_minstret[63:32];
            12'hF11: return 32'h7973_7978;
            12'hF12: return 32'h015F_DF0C;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic csr_writable(input logic [11:0] a);
        return (a == 12'h300) || (a == 12'h305) || (a == 12'h341) || (a == 12'h342) ||
               (a == 12'hB00) || (a == 12'hB80) || (a == 12'hB02) || (a == 12'hB82);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        i_valid = 0; i_pc = 0; i_pc_next = 0; i_res = 0; i_rd_addr = 0; i_csr_addr = 0;
        i_wen = 0; i_csr_wen = 0; i_ecall = 0; i_mret = 0; i_ebreak = 0;
        i_raddr1 = 0; i_raddr2 = 0; i_csr_raddr = 0;
    endtask

    // Applies the architectural effect of the current inputs to the model and
    // advances one clock; returns 1 time unit after the rising edge.
    task automatic step();
        logic        c;
        logic [63:0] nc, ni;
        logic [31:0] tgt, ms;
        c   = i_valid && !m_halt;
        nc  = m_mcycle + 64'd1;
        ni  = m_minstret + (c ? 64'd1 : 64'd0);
        tgt = i_pc_next;
        ms  = m_mstatus;
        if (c) begin
            if (i_wen && i_rd_addr != 4'd0) m_gpr[i_rd_addr] = i_res;
            if (i_ecall) begin
                m_mepc   = i_pc;
                m_mcause = 32'd11;
                ms  = (ms & ~32'h0000_0088) | 32'h0000_1800 | (ms[3] ? 32'h80 : 32'h0);
                tgt = m_mtvec & 32'hFFFF_FFFC;
            end else if (i_mret) begin
                ms  = (ms & ~32'h0000_0008) | 32'h0000_1880 | (ms[7] ? 32'h8 : 32'h0);
                tgt = m_mepc;
            end else if (i_csr_wen) begin
                case (i_csr_addr)
                    12'h300: ms = i_res;
                    12'h305: m_mtvec = i_res;
                    12'h341: m_mepc = i_res;
                    12'h342: m_mcause = i_res;
                    12'hB00: nc = {nc[63:32], i_res};
                    12'hB80: nc = {i_res, nc[31:0]};
                    12'hB02: ni = {ni[63:32], i_res};
                    12'hB82: ni = {i_res, ni[31:0]};
                    default: ;
                endcase
            end
        end
        m_mstatus  = ms;
        m_mcycle   = nc;
        m_minstret = ni;
        @(posedge clock);
        #1;
        if (c && i_ebreak) m_halt = 1'b1;
        m_commit_q = c;
        if (c) m_target_q = tgt;
    endtask

    task automatic rd_csr(input logic [11:0] a, output logic [31:0] v);
        i_csr_raddr = a;
        #1;
        v = o_csr_rdata;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] v;
        drive_idle();
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
        n_checks++; if (o_halt !== 1'b0) begin n_fail++; $display("FAIL rst_halt: got %b expected 0", o_halt); end
        n_checks++; if (o_retire !== 1'b0 || o_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got %b%b expected 00", o_retire, o_redirect_valid); end
        n_checks++; if (o_redirect_pc !== 32'd0) begin n_fail++; $display("FAIL rst_redirect_pc: got %h expected 0", o_redirect_pc); end
        @(posedge clock); #1;
        reset = 1'b1;
        rd_csr(12'h300, v);
        n_checks++; if (v !== 32'h0000_1800) begin n_fail++; $display("FAIL rst_mstatus: got %h expected 00001800", v); end
        for (int k = 0; k < 5; k++) begin
            i_raddr1 = 4'(k * 3);
            i_raddr2 = 4'(k * 3 + 1);
            #1;
            n_checks++; if (o_rdata1 !== 32'd0 || o_rdata2 !== 32'd0) begin n_fail++; $display("FAIL rst_gpr x%0d/x%0d: got %h %h expected 0", i_raddr1, i_raddr2, o_rdata1, o_rdata2); end
            step();
        end
        rd_csr(12'hB00, v);
        n_checks++; if (v !== 32'd5) begin n_fail++; $display("FAIL rst_mcycle: got %0d expected 5", v); end
        rd_csr(12'hB80, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_mcycleh: got %0d expected 0", v); end
        rd_csr(12'hB02, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL rst_minstret: got %0d expected 0", v); end
    endtask

    task automatic test_gpr_bypass();
        drive_idle();
        i_valid = 1; i_wen = 1; i_rd_addr = 4'd5; i_res = 32'hDEAD_BEEF;
        i_pc = 32'h8000_0000; i_pc_next = 32'h8000_0004; i_raddr1 = 4'd5;
        #1;
        n_checks++; if (o_rdata1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL gpr_bypass: got %h expected deadbeef", o_rdata1); end
        step();
        drive_idle();
        i_raddr1 = 4'd5;
        n_checks++; if (o_redirect_valid !== 1'b1 || o_retire !== 1'b1) begin n_fail++; $display("FAIL commit_pulses: got %b%b expected 11", o_redirect_valid, o_retire); end
        n_checks++; if (o_redirect_pc !== 32'h8000_0004) begin n_fail++; $display("FAIL commit_redirect_pc: got %h expected 80000004", o_redirect_pc); end
        #1;
        n_checks++; if (o_rdata1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL gpr_stored: got %h expected deadbeef", o_rdata1); end
        i_valid = 1; i_wen = 1; i_rd_addr = 4'd0; i_res = 32'h1234_5678; i_raddr1 = 4'd0;
        #1;
        n_checks++; if (o_rdata1 !== 32'd0) begin n_fail++; $display("FAIL x0_bypass: got %h expected 0", o_rdata1); end
        step();
        i_valid = 0; i_rd_addr = 4'd6; i_raddr2 = 4'd6; i_res = 32'h0BAD_0BAD;
        #1;
        n_checks++; if (o_rdata1 !== 32'd0) begin n_fail++; $display("FAIL x0_write: got %h expected 0", o_rdata1); end
        n_checks++; if (o_rdata2 !== 32'd0) begin n_fail++; $display("FAIL no_commit_bypass: got %h expected 0", o_rdata2); end
        step();
        n_checks++; if (o_retire !== 1'b0 || o_redirect_valid !== 1'b0) begin n_fail++; $display("FAIL idle_pulses: got %b%b expected 00", o_retire, o_redirect_valid); end
    endtask

    task automatic test_ecall();
        logic [31:0] v;
        drive_idle();
        i_valid = 1; i_csr_wen = 1; i_csr_addr = 12'h305; i_res = 32'h8000_0101;
        step();
        i_csr_addr = 12'h300; i_res = 32'h0000_1808;
        step();
        drive_idle();
        i_valid = 1; i_ecall = 1; i_pc = 32'h8000_0010; i_pc_next = 32'h8000_0014;
        rd_csr(12'h305, v);
        n_checks++; if (v !== 32'h8000_0101) begin n_fail++; $display("FAIL mtvec_write: got %h expected 80000101", v); end
        step();
        drive_idle();
        n_checks++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL ecall_redirect: got %b %h expected 1 80000100", o_redirect_valid, o_redirect_pc); end
        rd_csr(12'h341, v);
        n_checks++; if (v !== 32'h8000_0010) begin n_fail++; $display("FAIL ecall_mepc: got %h expected 80000010", v); end
        rd_csr(12'h342, v);
        n_checks++; if (v !== 32'd11) begin n_fail++; $display("FAIL ecall_mcause: got %h expected 0000000b", v); end
        rd_csr(12'h300, v);
        n_checks++; if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL ecall_mstatus: got %h expected 00001880", v); end
    endtask

    task automatic test_mret();
        logic [31:0] v;
        drive_idle();
        i_valid = 1; i_csr_wen = 1; i_csr_addr = 12'h300; i_res = 32'h0000_0080;
        step();
        drive_idle();
        i_valid = 1; i_mret = 1; i_pc = 32'h8000_0020; i_pc_next = 32'h8000_0024;
        step();
        drive_idle();
        n_checks++; if (o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL mret_redirect: got %b %h expected 1 80000010", o_redirect_valid, o_redirect_pc); end
        rd_csr(12'h300, v);
        n_checks++; if (v !== 32'h0000_1888) begin n_fail++; $display("FAIL mret_mstatus: got %h expected 00001888", v); end
        i_valid = 1; i_ecall = 1; i_mret = 1; i_pc = 32'h8000_0030; i_pc_next = 32'h8000_0034;
        i_csr_wen = 1; i_csr_addr = 12'h341; i_res = 32'h0000_0055;
        rd_csr(12'h341, v);
        n_checks++; if (v !== 32'h8000_0010) begin n_fail++; $display("FAIL ecall_no_csr_bypass: got %h expected 80000010", v); end
        step();
        drive_idle();
        n_checks++; if (o_redirect_pc !== 32'h8000_0100) begin n_fail++; $display("FAIL ecall_mret_redirect: got %h expected 80000100", o_redirect_pc); end
        rd_csr(12'h341, v);
        n_checks++; if (v !== 32'h8000_0030) begin n_fail++; $display("FAIL ecall_mret_mepc: got %h expected 80000030", v); end
        rd_csr(12'h300, v);
        n_checks++; if (v !== 32'h0000_1880) begin n_fail++; $display("FAIL ecall_mret_mstatus: got %h expected 00001880", v); end
    endtask

    task automatic test_csr_misc();
        logic [31:0] v;
        drive_idle();
        rd_csr(12'hF11, v);
        n_checks++; if (v !== 32'h7973_7978) begin n_fail++; $display("FAIL mvendorid: got %h expected 79737978", v); end
        rd_csr(12'hF12, v);
        n_checks++; if (v !== 32'h015F_DF0C) begin n_fail++; $display("FAIL marchid: got %h expected 015fdf0c", v); end
        i_valid = 1; i_csr_wen = 1; i_csr_addr = 12'hF11; i_res = 32'd0;
        step();
        i_csr_addr = 12'h123; i_res = 32'hDEAD_0000;
        step();
        i_csr_addr = 12'h342; i_res = 32'hCAFE_0001;
        rd_csr(12'h342, v);
        n_checks++; if (v !== 32'hCAFE_0001) begin n_fail++; $display("FAIL csr_bypass: got %h expected cafe0001", v); end
        step();
        drive_idle();
        rd_csr(12'hF11, v);
        n_checks++; if (v !== 32'h7973_7978) begin n_fail++; $display("FAIL ro_write_ignored: got %h expected 79737978", v); end
        rd_csr(12'h123, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL unimpl_csr: got %h expected 0", v); end
        rd_csr(12'h342, v);
        n_checks++; if (v !== 32'hCAFE_0001) begin n_fail++; $display("FAIL csr_stored: got %h expected cafe0001", v); end
    endtask

    task automatic test_counters();
        logic [31:0] v, hi0, lo0;
        drive_idle();
        hi0 = m_mcycle[63:32];
        i_valid = 1; i_csr_wen = 1; i_csr_addr = 12'hB00; i_res = 32'hFFFF_FFFF;
        step();
        drive_idle();
        rd_csr(12'hB00, v);
        n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mcycle_write: got %h expected ffffffff", v); end
        step();
        step();
        rd_csr(12'hB00, v);
        n_checks++; if (v !== 32'd1) begin n_fail++; $display("FAIL mcycle_wrap_lo: got %h expected 1", v); end
        rd_csr(12'hB80, v);
        n_checks++; if (v !== hi0 + 32'd1) begin n_fail++; $display("FAIL mcycle_carry_hi: got %h expected %h", v, hi0 + 32'd1); end
        lo0 = m_minstret[31:0];
        i_valid = 1; i_csr_wen = 1; i_csr_addr = 12'hB82; i_res = 32'h0000_0012;
        step();
        i_csr_addr = 12'hB02; i_res = 32'hFFFF_FFFF;
        rd_csr(12'hB02, v);
        n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL minstret_bypass: got %h expected ffffffff", v); end
        n_checks++; if (lo0 + 32'd1 !== m_minstret[31:0]) begin n_fail++; $display("FAIL minstret_model: got %h expected %h", m_minstret[31:0], lo0 + 32'd1); end
        step();
        drive_idle();
        i_valid = 1;
        step();
        drive_idle();
        rd_csr(12'hB02, v);
        n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL minstret_wrap_lo: got %h expected 0", v); end
        rd_csr(12'hB82, v);
        n_checks++; if (v !== 32'h0000_0013) begin n_fail++; $display("FAIL minstret_carry_hi: got %h expected 00000013", v); end
        rd_csr(12'hB00, v);
        n_checks++; if (v !== m_mcycle[31:0]) begin n_fail++; $display("FAIL mcycle_track: got %h expected %h", v, m_mcycle[31:0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int k = 0; k < 4; k++) begin
            drive_idle();
            i_valid = 1; i_wen = 1; i_rd_addr = 4'(7 + k); i_res = 32'h100 + k;
            i_pc = 32'h0000_0100 + 32'(4 * k); i_pc_next = i_pc + 32'd4;
            step();
            n_checks++; if (o_retire !== 1'b1 || o_redirect_valid !== 1'b1 || o_redirect_pc !== 32'h0000_0104 + 32'(4 * k)) begin n_fail++; $display("FAIL b2b_%0d: got %b%b %h expected 11 %h", k, o_retire, o_redirect_valid, o_redirect_pc, 32'h0000_0104 + 32'(4 * k)); end
        end
        drive_idle();
        rd_csr(12'hB02, v);
        n_checks++; if (v !== m_minstret[31:0]) begin n_fail++; $display("FAIL b2b_minstret: got %h expected %h", v, m_minstret[31:0]); end
    endtask

    task automatic test_random();
        logic        c;
        logic [31:0] e1, e2, ec;
        for (int n = 0; n < 300; n++) begin
            i_valid     = ($urandom_range(0, 3) != 0);
            i_pc        = $urandom & 32'hFFFF_FFFC;
            i_pc_next   = ($urandom_range(0, 1) != 0) ? i_pc + 32'd4 : ($urandom & 32'hFFFF_FFFC);
            i_res       = $urandom;
            i_rd_addr   = 4'($urandom_range(0, 15));
            i_wen       = 1'($urandom_range(0, 1));
            i_csr_wen   = ($urandom_range(0, 2) == 0);
            i_csr_addr  = csr_list[$urandom_range(0, 10)];
            i_ecall     = ($urandom_range(0, 15) == 0);
            i_mret      = ($urandom_range(0, 15) == 0);
            i_ebreak    = 1'b0;
            i_raddr1    = 4'($urandom_range(0, 15));
            i_raddr2    = ($urandom_range(0, 1) != 0) ? i_rd_addr : 4'($urandom_range(0, 15));
            i_csr_raddr = ($urandom_range(0, 1) != 0) ? i_csr_addr : csr_list[$urandom_range(0, 10)];
            #1;
            c  = i_valid && !m_halt;
            e1 = (c && i_wen && i_rd_addr != 4'd0 && i_rd_addr == i_raddr1) ? i_res : m_gpr[i_raddr1];
            e2 = (c && i_wen && i_rd_addr != 4'd0 && i_rd_addr == i_raddr2) ? i_res : m_gpr[i_raddr2];
            ec = (c && i_csr_wen && !i_ecall && !i_mret && csr_writable(i_csr_addr) && i_csr_raddr == i_csr_addr) ? i_res : model_csr(i_csr_raddr);
            n_checks++; if (o_rdata1 !== e1) begin n_fail++; $display("FAIL rnd_rdata1[%0d]: got %h expected %h", n, o_rdata1, e1); end
            n_checks++; if (o_rdata2 !== e2) begin n_fail++; $display("FAIL rnd_rdata2[%0d]: got %h expected %h", n, o_rdata2, e2); end
            n_checks++; if (o_csr_rdata !== ec) begin n_fail++; $display("FAIL rnd_csr[%0d] addr %h: got %h expected %h", n, i_csr_raddr, o_csr_rdata, ec); end
            step();
            n_checks++; if (o_retire !== m_commit_q || o_redirect_valid !== m_commit_q) begin n_fail++; $display("FAIL rnd_pulses[%0d]: got %b%b expected %b", n, o_retire, o_redirect_valid, m_commit_q); end
            if (m_commit_q) begin
                n_checks++; if (o_redirect_pc !== m_target_q) begin n_fail++; $display("FAIL rnd_redirect_pc[%0d]: got %h expected %h", n, o_redirect_pc, m_target_q); end
            end
        end
        drive_idle();
    endtask

    task automatic test_halt();
        logic [31:0] v;
        drive_idle();
        i_valid = 1; i_wen = 1; i_rd_addr = 4'd1; i_res = 32'hA5A5_A5A5; i_ebreak = 1;
        i_pc = 32'h0000_01FC; i_pc_next = 32'h0000_0200;
        #1;
        n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL ebreak_ready_before: got %b expected 1", o_ready); end
        step();
        drive_idle();
        n_checks++; if (o_retire !== 1'b1 || o_redirect_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL ebreak_retire: got %b %h expected 1 00000200", o_retire, o_redirect_pc); end
        n_checks++; if (o_halt !== 1'b1 || o_ready !== 1'b0) begin n_fail++; $display("FAIL ebreak_halt: got halt %b ready %b expected 1 0", o_halt, o_ready); end
        i_raddr1 = 4'd1;
        #1;
        n_checks++; if (o_rdata1 !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ebreak_gpr: got %h expected a5a5a5a5", o_rdata1); end
        for (int k = 0; k < 3; k++) begin
            i_valid = 1; i_wen = 1; i_rd_addr = 4'd2; i_res = 32'h1111_0000 + k; i_raddr2 = 4'd2;
            i_csr_wen = 1; i_csr_addr = 12'h305; i_res = 32'h2222_0000 + k;
            #1;
            n_checks++; if (o_rdata2 !== m_gpr[2]) begin n_fail++; $display("FAIL halt_no_bypass: got %h expected %h", o_rdata2, m_gpr[2]); end
            step();
            n_checks++; if (o_retire !== 1'b0 || o_redirect_valid !== 1'b0 || o_ready !== 1'b0) begin n_fail++; $display("FAIL halt_stuck_%0d: got %b%b%b expected 000", k, o_retire, o_redirect_valid, o_ready); end
        end
        drive_idle();
        rd_csr(12'h305, v);
        n_checks++; if (v !== m_mtvec) begin n_fail++; $display("FAIL halt_mtvec: got %h expected %h", v, m_mtvec); end
        rd_csr(12'hB02, v);
        n_checks++; if (v !== m_minstret[31:0]) begin n_fail++; $display("FAIL halt_minstret: got %h expected %h", v, m_minstret[31:0]); end
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (o_ready !== 1'b1 || o_halt !== 1'b0) begin n_fail++; $display("FAIL halt_reset: got ready %b halt %b expected 1 0", o_ready, o_halt); end
        @(posedge clock); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset_discard();
        drive_idle();
        i_valid = 1; i_wen = 1; i_rd_addr = 4'd3; i_res = 32'h77; i_pc_next = 32'h300;
        step();
        n_checks++; if (o_retire !== 1'b1) begin n_fail++; $display("FAIL pre_reset_retire: got %b expected 1", o_retire); end
        reset = 1'b0;
        model_reset();
        #1;
        n_checks++; if (o_retire !== 1'b0 || o_redirect_valid !== 1'b0 || o_redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_clears_pulse: got %b%b %h expected 00 0", o_retire, o_redirect_valid, o_redirect_pc); end
        i_rd_addr = 4'd4; i_res = 32'h88;
        @(posedge clock); #1;
        reset = 1'b1;
        drive_idle();
        i_raddr1 = 4'd3; i_raddr2 = 4'd4;
        #1;
        n_checks++; if (o_rdata1 !== 32'd0 || o_rdata2 !== 32'd0) begin n_fail++; $display("FAIL reset_discard: got %h %h expected 0 0", o_rdata1, o_rdata2); end
        step();
        n_checks++; if (o_retire !== 1'b0) begin n_fail++; $display("FAIL post_reset_retire: got %b expected 0", o_retire); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_gpr_bypass();
        test_ecall();
        test_mret();
        test_csr_misc();
        test_counters();
        test_back_to_back();
        test_random();
        test_halt();
        test_reset_discard();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
